// File: rtl/button_event_detector.sv
// Classifies debounced button activity into short press, long press and double click.
// Every output is registered; pulses last exactly one clk cycle.
module button_event_detector #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int CNT_W       = $clog2((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_debounced,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       pressed,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_ARM      = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_PRESSED  = 3'd2;
  localparam logic [2:0] ST_HELD     = 3'd3;
  localparam logic [2:0] ST_WAIT_GAP = 3'd4;
  localparam logic [2:0] ST_SECOND   = 3'd5;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_pressed;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_double_nxt;
  logic             w_pressed_nxt;

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ARM;
      r_cnt     <= '0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
      r_double  <= w_double_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  // A release always wins over long expiry, and a repress always wins over gap expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ARM: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (pb_debounced) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESSED: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_WAIT_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_GAP: begin
        if (pb_debounced) begin
          w_state_nxt = ST_SECOND;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SECOND: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_ARM;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses decode the transition taken; the pressed level decodes the destination.
  always_comb begin
    w_long_nxt    = (r_state == ST_PRESSED)  && (w_state_nxt == ST_HELD);
    w_short_nxt   = (r_state == ST_WAIT_GAP) && (w_state_nxt == ST_IDLE);
    w_double_nxt  = (r_state == ST_WAIT_GAP) && (w_state_nxt == ST_SECOND);
    w_pressed_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_HELD) ||
                    (w_state_nxt == ST_SECOND);
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_click = r_double;
  assign pressed      = r_pressed;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: directed scenarios and random press/release
// trains, each checked cycle by cycle against a run-length event model.
module tb_button_event_detector;

  localparam int L = 8;
  localparam int G = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       pb;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic       pressed;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  bit         seq_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  button_event_detector #(
    .LONG_CYCLES(L),
    .GAP_CYCLES (G),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_debounced(pb),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .pressed     (pressed),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset(input bit pb_level);
    @(negedge clk);
    rst = 1'b1;
    pb  = pb_level;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq_q.delete();
  endtask

  // Driver
  task automatic add_seg(input bit v, input int n);
    repeat (n) seq_q.push_back(v);
  endtask

  task automatic run_seq();
    obs_q.delete();
    for (int t = 0; t < seq_q.size(); t++) begin
      pb = seq_q[t];
      @(posedge clk);
      @(negedge clk);
      obs_q.push_back({short_press, long_press, double_click, pressed});
    end
  endtask

  // Reference model: bit3 short, bit2 long, bit1 double, bit0 pressed.
  // Works on runs of the sampled level: a press run longer than L is a long
  // press; a release run followed by a press within G edges is a double click.
  task automatic build_expected();
    int n;
    int t;
    int e0;
    int r;
    int s;
    int r2;
    logic [3:0] e[];
    n = seq_q.size();
    e = new[n];
    foreach (e[i]) e[i] = 4'b0000;
    t = 0;
    while (t < n && seq_q[t]) t++;
    t++;
    while (t < n) begin
      if (!seq_q[t]) begin
        t++;
        continue;
      end
      e0 = t;
      r  = e0;
      while (r < n && seq_q[r]) r++;
      for (int k = e0; k < r; k++) e[k][0] = 1'b1;
      if (r - e0 > L) begin
        if (e0 + L < n) e[e0 + L][2] = 1'b1;
        t = r + 1;
        continue;
      end
      if (r >= n) break;
      s = r + 1;
      while (s < n && !seq_q[s]) s++;
      if (s < n && s <= r + G) begin
        e[s][1] = 1'b1;
        r2 = s;
        while (r2 < n && seq_q[r2]) r2++;
        for (int k = s; k < r2; k++) e[k][0] = 1'b1;
        t = r2 + 1;
      end else begin
        if (r + G < n) e[r + G][3] = 1'b1;
        t = r + G + 1;
      end
    end
    exp_q.delete();
    foreach (e[i]) exp_q.push_back(e[i]);
  endtask

  function automatic int count_bit(input int b);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][b]) c++;
    return c;
  endfunction

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    pb  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({short_press, long_press, double_click, pressed} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got=%b exp=0000", {short_press, long_press, double_click, pressed});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_short();
    do_reset(1'b0);
    add_seg(1'b0, 2); add_seg(1'b1, 3); add_seg(1'b0, 12);
    build_expected();
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (count_bit(3) != 1 || count_bit(2) != 0 || count_bit(1) != 0 || count_bit(0) != 3) begin
      errors++;
      $display("FAIL short_counts got s=%0d l=%0d d=%0d p=%0d exp s=1 l=0 d=0 p=3",
               count_bit(3), count_bit(2), count_bit(1), count_bit(0));
    end
  endtask

  task automatic test_long();
    do_reset(1'b0);
    add_seg(1'b0, 2); add_seg(1'b1, 20); add_seg(1'b0, 10);
    build_expected();
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL long cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
    // press edge is cycle 2, so the pulse is sampled after edge 2+L
    checks++;
    if (obs_q[2 + L][2] !== 1'b1 || count_bit(2) != 1 || count_bit(3) != 0 || count_bit(0) != 20) begin
      errors++;
      $display("FAIL long_counts got l@%0d=%b l=%0d s=%0d p=%0d exp l@%0d=1 l=1 s=0 p=20",
               2 + L, obs_q[2 + L][2], count_bit(2), count_bit(3), count_bit(0), 2 + L);
    end
  endtask

  task automatic test_long_boundary();
    for (int len = L; len <= L + 1; len++) begin
      do_reset(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, len); add_seg(1'b0, 10);
      build_expected();
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL long_edge len=%0d cyc=%0d got=%b exp=%b", len, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (count_bit(2) != ((len > L) ? 1 : 0) || count_bit(3) != ((len > L) ? 0 : 1)) begin
        errors++;
        $display("FAIL long_edge_counts len=%0d got l=%0d s=%0d exp l=%0d s=%0d",
                 len, count_bit(2), count_bit(3), (len > L) ? 1 : 0, (len > L) ? 0 : 1);
      end
    end
  endtask

  task automatic test_double();
    do_reset(1'b0);
    add_seg(1'b0, 2); add_seg(1'b1, 2); add_seg(1'b0, 3); add_seg(1'b1, 2); add_seg(1'b0, 12);
    build_expected();
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL double cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[7][1] !== 1'b1 || count_bit(1) != 1 || count_bit(3) != 0 || count_bit(0) != 4) begin
      errors++;
      $display("FAIL double_counts got d@7=%b d=%0d s=%0d p=%0d exp d@7=1 d=1 s=0 p=4",
               obs_q[7][1], count_bit(1), count_bit(3), count_bit(0));
    end
  endtask

  task automatic test_gap_boundary();
    // zero run of G edges puts the repress on the expiry edge; G+1 misses it
    for (int gap = G; gap <= G + 1; gap++) begin
      do_reset(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 2); add_seg(1'b0, gap); add_seg(1'b1, 2); add_seg(1'b0, 12);
      build_expected();
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL gap_edge gap=%0d cyc=%0d got=%b exp=%b", gap, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (count_bit(1) != ((gap == G) ? 1 : 0) || count_bit(3) != ((gap == G) ? 0 : 2)) begin
        errors++;
        $display("FAIL gap_edge_counts gap=%0d got d=%0d s=%0d exp d=%0d s=%0d",
                 gap, count_bit(1), count_bit(3), (gap == G) ? 1 : 0, (gap == G) ? 0 : 2);
      end
    end
  endtask

  task automatic test_reset_hold();
    do_reset(1'b1);
    add_seg(1'b1, 5); add_seg(1'b0, 3); add_seg(1'b1, 2); add_seg(1'b0, 10);
    build_expected();
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (count_bit(3) != 1 || count_bit(2) != 0 || count_bit(1) != 0 || count_bit(0) != 2) begin
      errors++;
      $display("FAIL reset_hold_counts got s=%0d l=%0d d=%0d p=%0d exp s=1 l=0 d=0 p=2",
               count_bit(3), count_bit(2), count_bit(1), count_bit(0));
    end
  endtask

  task automatic test_reset_abort();
    do_reset(1'b0);
    add_seg(1'b0, 2); add_seg(1'b1, 3);
    build_expected();
    run_seq();
    checks++;
    if (obs_q[4] !== exp_q[4] || exp_q[4] !== 4'b0001) begin
      errors++;
      $display("FAIL abort_pre got=%b exp=0001", obs_q[4]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({short_press, long_press, double_click, pressed} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_pressed got=%b exp=0000", {short_press, long_press, double_click, pressed});
    end
    pb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq_q.delete();
    add_seg(1'b0, 2); add_seg(1'b1, 2); add_seg(1'b0, 3);
    build_expected();
    run_seq();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({short_press, long_press, double_click, pressed} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_gap got=%b exp=0000", {short_press, long_press, double_click, pressed});
    end
    @(negedge clk);
    rst = 1'b0;
    seq_q.delete();
    add_seg(1'b0, 12);
    build_expected();
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_after cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      do_reset(lvl);
      add_seg(lvl, $urandom_range(1, 3));
      for (int sg = 0; sg < 12; sg++) begin
        add_seg(1'b0, $urandom_range(1, G + 3));
        add_seg(1'b1, $urandom_range(1, L + 4));
      end
      add_seg(1'b0, G + 2);
      build_expected();
      run_seq();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pb  = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_long_boundary();
    test_double();
    test_gap_boundary();
    test_reset_hold();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
